// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl: detects a start bit, drives the sipo for WIDTH cycles and captures the word for a valid/ready consumer.
// Define PARITY_SEL_EN to add an even-parity bit after the data bits and report parity_err.
module sipo_frame_ctrl #(
    parameter int WIDTH       = 4,
    parameter bit START_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             serial,
    output logic             sipo_en,
    input  logic [WIDTH-1:0] sipo_parallel,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    input  logic             ready,
    output logic             overrun,
    input  logic             overrun_clr,
    output logic             parity_err,
    output logic             busy
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY, S_CAPTURE} state_t;

`ifdef PARITY_SEL_EN
    localparam state_t S_AFTER = S_PARITY;
`else
    localparam state_t S_AFTER = S_CAPTURE;
`endif

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_ovr;
    logic             w_start;
    logic             w_last;
    logic             w_cap;
    logic             w_take;

    assign w_start = en && (serial == START_LEVEL);
    assign w_last  = r_cnt == CW'(WIDTH - 1);
    assign w_cap   = r_state == S_CAPTURE;
    assign w_take  = w_cap && (!r_valid || ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:   w_next = w_start ? S_SHIFT : S_IDLE;
            S_SHIFT:  w_next = !en ? S_IDLE : (w_last ? S_AFTER : S_SHIFT);
            S_PARITY: w_next = en ? S_CAPTURE : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        sipo_en = en && (r_state == S_SHIFT);
        busy    = r_state != S_IDLE;
    end

    // Counter holds at WIDTH-1 on the last shift; it is only cleared by a new start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               r_cnt <= '0;
        else if (r_state == S_IDLE && w_start) r_cnt <= '0;
        else if (r_state == S_SHIFT && !w_last) r_cnt <= r_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_take) r_data <= sipo_parallel;
            r_valid <= w_take || (r_valid && !ready);
            r_ovr   <= !overrun_clr && (r_ovr || (w_cap && r_valid && !ready));
        end
    end

    assign data_out = r_data;
    assign valid    = r_valid;
    assign overrun  = r_ovr;

`ifdef PARITY_SEL_EN
    logic r_par_bit;
    logic r_perr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par_bit <= 1'b0;
            r_perr    <= 1'b0;
        end else begin
            if (r_state == S_PARITY) r_par_bit <= serial;
            if (w_take)              r_perr    <= ^{sipo_parallel, r_par_bit};
        end
    end

    assign parity_err = r_perr;
`else
    assign parity_err = 1'b0;
`endif
endmodule
